// File: rtl/turn_signal_conditioner.sv
// Purpose: synchronise, debounce and arbitrate raw turn-lever contacts; emit a free-running step_tick.
//          Build option TURN_SIGNAL_LAST_WINS_EN: while both levers are held, the one that rose last wins.
// Latency: raw edge to left/right = SYNC_STAGES+DEBOUNCE_CYCLES+1 clocks; no backpressure, all outputs free-running.
module turn_signal_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int STEP_CYCLES     = 6250000
) (
    input  logic clk,
    input  logic reset,
    input  logic left_raw,
    input  logic right_raw,
    output logic left,
    output logic right,
    output logic step_tick
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

    logic [1:0] raw_in;
    logic [1:0] stable;
    logic       stable_l;
    logic       stable_r;

    assign raw_in   = {right_raw, left_raw};
    assign stable_l = stable[0];
    assign stable_r = stable[1];

    // Channel 0 is left, channel 1 is right; both channels are identical and independent.
    genvar ch;
    generate
        for (ch = 0; ch < 2; ch++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_q;
            logic [CW-1:0]          cnt_q;
            logic                   stable_q;
            logic                   s;

            assign s          = sync_q[SYNC_STAGES-1];
            assign stable[ch] = stable_q;

            // Metastability chain: raw contact shifts in at bit 0, synced level leaves at the top.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in[ch]};
                end
            end

            // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else if (s == stable_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DB_LAST) begin
                    stable_q <= s;
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    endgenerate

    logic [SW-1:0] step_cnt;

    // Free-running pacing counter; the tick is registered so it lands STEP_CYCLES edges after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_cnt  <= '0;
            step_tick <= 1'b0;
        end else begin
            step_tick <= (step_cnt == STEP_LAST);
            step_cnt  <= (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
        end
    end

`ifdef TURN_SIGNAL_LAST_WINS_EN
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_LEFT  = 2'd1,
        OWN_RIGHT = 2'd2
    } owner_t;

    owner_t     owner_q;
    owner_t     owner_nxt;
    logic [1:0] stable_d;
    logic       rise_l;
    logic       rise_r;

    assign rise_l = stable_l & ~stable_d[0];
    assign rise_r = stable_r & ~stable_d[1];

    // Ownership follows the most recent rise; a simultaneous rise leaves nobody owning.
    always_comb begin
        owner_nxt = owner_q;
        case ({stable_r, stable_l})
            2'b00:   owner_nxt = OWN_NONE;
            2'b01:   owner_nxt = OWN_LEFT;
            2'b10:   owner_nxt = OWN_RIGHT;
            default: begin
                if (rise_l && rise_r) begin
                    owner_nxt = OWN_NONE;
                end else if (rise_l) begin
                    owner_nxt = OWN_LEFT;
                end else if (rise_r) begin
                    owner_nxt = OWN_RIGHT;
                end
            end
        endcase
    end

    // Registered, mutually exclusive requests; the owner breaks the tie when both are held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q  <= OWN_NONE;
            stable_d <= 2'b00;
            left     <= 1'b0;
            right    <= 1'b0;
        end else begin
            owner_q  <= owner_nxt;
            stable_d <= stable;
            left     <= stable_l & (~stable_r | (owner_nxt == OWN_LEFT));
            right    <= stable_r & (~stable_l | (owner_nxt == OWN_RIGHT));
        end
    end
`else
    // Registered, mutually exclusive requests; both held cancels both.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            left  <= 1'b0;
            right <= 1'b0;
        end else begin
            left  <= stable_l & ~stable_r;
            right <= stable_r & ~stable_l;
        end
    end
`endif

endmodule

// File: tb/tb_turn_signal_conditioner.sv
// Directed bench for turn_signal_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, STEP_CYCLES=8.
// Inputs change and outputs are sampled on the falling edge; edge counts are rising edges since the change.
// Expected end-to-end latency for a clean lever edge is 2+4+1 = 7 rising edges.
module tb_turn_signal_conditioner;

    logic clk;
    logic reset;
    logic left_raw;
    logic right_raw;
    logic left;
    logic right;
    logic step_tick;

    int n_checks = 0;
    int n_fail   = 0;

    turn_signal_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .STEP_CYCLES    (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .left_raw (left_raw),
        .right_raw(right_raw),
        .left     (left),
        .right    (right),
        .step_tick(step_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance exactly one rising edge, landing on the following falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    // Step n edges; outputs hold the "before" values until edge n, where they take the "after" values.
    task automatic watch(input string tag, input int n,
                         input logic lb, input logic la, input logic rb, input logic ra);
        for (int k = 1; k <= n; k++) begin
            step();
            check({tag, "_left"},  left,  (k >= n) ? la : lb);
            check({tag, "_right"}, right, (k >= n) ? ra : rb);
        end
    endtask

    initial begin
        reset     = 1'b0;
        left_raw  = 1'b0;
        right_raw = 1'b0;

        // 1: reset state, then step_tick at edges 8, 16, 24 after release.
        repeat (3) step();
        check("rst_left",  left,      1'b0);
        check("rst_right", right,     1'b0);
        check("rst_tick",  step_tick, 1'b0);
        reset = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            step();
            check("tick", step_tick, (k % 8 == 0) ? 1'b1 : 1'b0);
        end
        check("idle_left",  left,  1'b0);
        check("idle_right", right, 1'b0);

        // 2: clean press and release of the left lever.
        left_raw = 1'b1;
        watch("clean_rise", 7, 1'b0, 1'b1, 1'b0, 1'b0);
        left_raw = 1'b0;
        watch("clean_fall", 7, 1'b1, 1'b0, 1'b0, 1'b0);

        // 3: bouncing contact, then a steady hold.
        for (int i = 0; i < 4; i++) begin
            left_raw = (i % 2 == 0);
            for (int j = 0; j < 3; j++) begin
                step();
                check("bounce_left", left, 1'b0);
            end
        end
        left_raw = 1'b1;
        watch("bounce_settle", 7, 1'b0, 1'b1, 1'b0, 1'b0);
        left_raw = 1'b0;
        watch("bounce_release", 7, 1'b1, 1'b0, 1'b0, 1'b0);

        // 4: right held, left pressed on top, then left released.
        right_raw = 1'b1;
        watch("right_only", 7, 1'b0, 1'b0, 1'b0, 1'b1);
        left_raw = 1'b1;
`ifdef TURN_SIGNAL_LAST_WINS_EN
        watch("left_over_right", 7, 1'b0, 1'b1, 1'b1, 1'b0);
        left_raw = 1'b0;
        watch("left_off_right_back", 7, 1'b1, 1'b0, 1'b0, 1'b1);
`else
        watch("left_over_right", 7, 1'b0, 1'b0, 1'b1, 1'b0);
        left_raw = 1'b0;
        watch("left_off_right_back", 7, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
        right_raw = 1'b0;
        watch("right_off", 7, 1'b0, 1'b0, 1'b1, 1'b0);

        // 5: both levers rise on the same cycle.
        left_raw  = 1'b1;
        right_raw = 1'b1;
        watch("both_rise", 10, 1'b0, 1'b0, 1'b0, 1'b0);
        left_raw  = 1'b0;
        right_raw = 1'b0;
        watch("both_fall", 8, 1'b0, 1'b0, 1'b0, 1'b0);

        // 6a: reset in the middle of a debounce count (counter at 2).
        left_raw = 1'b1;
        repeat (4) step();
        reset = 1'b0;
        #1;
        check("rst_mid_db_left", left, 1'b0);
        step();
        reset = 1'b1;
        watch("after_rst_db", 7, 1'b0, 1'b1, 1'b0, 1'b0);

        // 6b: reset while left is asserted clears it immediately.
        step();
        check("pre_rst_left", left, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_async_left",  left,      1'b0);
        check("rst_async_tick",  step_tick, 1'b0);
        step();
        step();
        check("rst_hold_left", left, 1'b0);
        reset = 1'b1;
        watch("after_rst_held", 7, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("tick_after_rst", step_tick, 1'b1);
        step();
        check("tick_one_wide", step_tick, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
